// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    DISCARD = 2'b10
  } fetch_state_t;

  // Next-PC select encodings; any value with bit 1 set selects ALUResult.
  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_ALU    = 2'b10;

  // Instruction presented to decode when nothing valid is buffered.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One buffered fetch: instruction address and instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Pick the redirect target for a given PCSrc.
  function automatic logic [31:0] select_target(input logic [1:0] pcsrc,
                                                input logic [31:0] pc_target,
                                                input logic [31:0] alu_result);
    return pcsrc[1] ? alu_result : pc_target;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer of fetched instructions with push, pop and flush.
// Pop and push in the same cycle are allowed even when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;
  logic         do_pop;
  logic         do_push;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == DEPTH_CNT);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers and occupancy; flush empties the buffer on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_pop)  rd_ptr <= ~rd_ptr;
      if (do_push) wr_ptr <= ~wr_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, two-entry
// instruction buffer, redirect with in-flight response discard.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target raises
// a sticky misaligned flag and halts fetch until an aligned redirect; without
// it, target bits [1:0] are cleared and misaligned is tied low.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        misaligned
);

  localparam logic [1:0] DEPTH_CNT = 2'(FIFO_DEPTH);

  fetch_state_t state, state_next;
  logic [31:0]  fetch_pc;
  logic         redir;
  logic         trap;
  logic         misaligned_q;
  logic [31:0]  raw_target;
  logic [31:0]  aligned_target;
  logic         push;
  logic         pop;
  logic         flush;
  logic         empty;
  logic         full;
  logic [1:0]   occ;
  logic [1:0]   occ_after_pop;
  fetch_entry_t head;
  fetch_entry_t push_data;

  // A redirect selecting PC+4 is not a control transfer and is ignored.
  assign redir          = redirect && (PCSrc != PCSRC_PLUS4);
  assign raw_target     = select_target(PCSrc, PCTarget, ALUResult);
  assign aligned_target = raw_target & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap = redir && (raw_target[1:0] != 2'b00);

  // Sticky trap flag: each effective redirect sets or clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     misaligned_q <= 1'b0;
    else if (redir) misaligned_q <= trap;
  end
`else
  assign trap         = 1'b0;
  assign misaligned_q = 1'b0;
`endif

  assign misaligned    = misaligned_q;
  assign pop           = !empty && instr_ready;
  assign occ_after_pop = occ - {1'b0, pop};
  assign push_data     = '{pc: fetch_pc, instr: imem_rdata};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (occ)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and buffer controls; redirect takes priority over everything.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        if (redir) begin
          flush      = 1'b1;
          state_next = trap ? IDLE : REQ;
        end else if (!misaligned_q && (occ_after_pop < DEPTH_CNT)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (redir) begin
          flush = 1'b1;
          if (imem_ack) state_next = trap ? IDLE : REQ;
          else          state_next = DISCARD;
        end else if (imem_ack) begin
          push       = 1'b1;
          state_next = ((occ_after_pop + 2'd1) < DEPTH_CNT) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (redir)    flush      = 1'b1;
        if (imem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fetch address: load redirect target, else advance on each accepted response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          fetch_pc <= RESET_PC;
    else if (redir)                      fetch_pc <= aligned_target;
    else if ((state == REQ) && imem_ack) fetch_pc <= fetch_pc + 32'd4;
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = fetch_pc;
  assign instr_valid = !empty;
  assign Instr       = empty ? NOP_INSTR : head.instr;
  assign PC          = empty ? 32'd0 : head.pc;
  assign PCPlus4     = empty ? 32'd0 : head.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected retirements.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] PCTarget = '0;
  logic [31:0] ALUResult = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        misaligned;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .PCSrc      (PCSrc),
    .PCTarget   (PCTarget),
    .ALUResult  (ALUResult),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .Instr      (Instr),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: retire check just before the edge, then settle after it.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_retire", {31'b0, instr_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("retire_instr", Instr, e.instr);
        chk("retire_pc", PC, e.pc);
        chk("retire_pcplus4", PCPlus4, e.pc + 32'd4);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Serve one request at addr after hold idle cycles; response is expected to retire.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input int hold);
    exp_t e;
    int w = 0;
    while (!imem_req && w < 10) begin
      step();
      w++;
    end
    chk("req_seen", {31'b0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, addr);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("req_hold", {31'b0, imem_req}, 32'd1);
      chk("addr_hold", imem_addr, addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    e.pc = addr;
    e.instr = data;
    sb.push_back(e);
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic clear_redirect();
    redirect   = 1'b0;
    PCSrc      = 2'b00;
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", Instr, 32'h0000_0013);
    chk("rst_pc", PC, 32'd0);
    chk("rst_pcplus4", PCPlus4, 32'd0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset       = 1'b1;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);

    // Streaming fetch 0,4,8
    fetch_one(32'h0, 32'hA000_0000, 1);
    fetch_one(32'h4, 32'hA000_0001, 0);
    fetch_one(32'h8, 32'hA000_0002, 1);

    // Decode stall fills the buffer
    instr_ready = 1'b0;
    fetch_one(32'hC, 32'hA000_0003, 0);
    chk("full_no_req", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_no_req", {31'b0, imem_req}, 32'd0);
      chk("stall_head_pc", PC, 32'h8);
    end
    instr_ready = 1'b1;
    step();
    fetch_one(32'h10, 32'hA000_0004, 0);

    // Redirect with outstanding request, response arrives 3 cycles later
    redirect = 1'b1;
    PCSrc    = 2'b01;
    PCTarget = 32'h100;
    step();
    clear_redirect();
    sb.delete();
    chk("discard_no_req", {31'b0, imem_req}, 32'd0);
    chk("discard_flushed", {31'b0, instr_valid}, 32'd0);
    step();
    step();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_0001;
    step();
    imem_ack   = 1'b0;
    chk("dropped_valid", {31'b0, instr_valid}, 32'd0);
    fetch_one(32'h100, 32'hA000_0005, 0);

    // Redirect via ALUResult coincident with ack
    redirect   = 1'b1;
    PCSrc      = 2'b11;
    ALUResult  = 32'h204;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_0002;
    step();
    clear_redirect();
    sb.delete();
    chk("coinc_valid", {31'b0, instr_valid}, 32'd0);
    chk("coinc_req", {31'b0, imem_req}, 32'd1);
    chk("coinc_addr", imem_addr, 32'h204);
    fetch_one(32'h204, 32'hA000_0006, 0);

    // Redirect with PCSrc=00 is ignored
    redirect = 1'b1;
    PCSrc    = 2'b00;
    PCTarget = 32'h300;
    fetch_one(32'h208, 32'hA000_0007, 0);
    clear_redirect();
    chk("plus4_next_addr", imem_addr, 32'h20C);

    // Misaligned target
    redirect   = 1'b1;
    PCSrc      = 2'b01;
    PCTarget   = 32'h102;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_0003;
    step();
    clear_redirect();
    sb.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("trap_flag", {31'b0, misaligned}, 32'd1);
    chk("trap_no_req", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("trap_halt", {31'b0, imem_req}, 32'd0);
      chk("trap_sticky", {31'b0, misaligned}, 32'd1);
    end
    redirect = 1'b1;
    PCSrc    = 2'b01;
    PCTarget = 32'h200;
    step();
    clear_redirect();
    chk("trap_cleared", {31'b0, misaligned}, 32'd0);
    fetch_one(32'h200, 32'hA000_0008, 0);
`else
    chk("noflag_misaligned", {31'b0, misaligned}, 32'd0);
    fetch_one(32'h100, 32'hA000_0008, 0);
`endif

    // Address wrap at the top of memory
    redirect   = 1'b1;
    PCSrc      = 2'b10;
    ALUResult  = 32'hFFFF_FFFC;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_0004;
    step();
    clear_redirect();
    sb.delete();
    fetch_one(32'hFFFF_FFFC, 32'hA000_0009, 0);
    fetch_one(32'h0, 32'hA000_000A, 0);
    chk("wrap_no_flag", {31'b0, misaligned}, 32'd0);

    // Asynchronous reset mid-request
    chk("pre_reset_req", {31'b0, imem_req}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_valid", {31'b0, instr_valid}, 32'd0);
    chk("arst_instr", Instr, 32'h0000_0013);
    chk("arst_pc", PC, 32'd0);
    chk("arst_pcplus4", PCPlus4, 32'd0);
    chk("arst_misaligned", {31'b0, misaligned}, 32'd0);
    sb.delete();
    #2;
    @(negedge clk);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_0005;
    @(posedge clk);
    #1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    chk("rel_req", {31'b0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'd0);
    chk("rel_valid", {31'b0, instr_valid}, 32'd0);
    fetch_one(32'h0, 32'hA000_000B, 0);
    step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
